md_hilo_unit: RTL

Execute-stage consumer of the packed ID/EX control bundles for MIPS multiply/divide and HI/LO traffic. It decodes the `md_*` fields of the EX bundle and the `lhr_*` fields of the MEM bundle. It runs iterative 32-bit mult/multu/div/divu, owns the HI and LO registers, and services mthi/mtlo/mfhi/mflo. It asserts a pipeline stall while a result is pending.

---
 rtl/md_pkg.sv | 10 +
 rtl/md_iter_core.sv | 39 +++
 rtl/md_hilo_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: bundle bit indices and FSM encoding shared by the multiply/divide HI/LO unit
package md_pkg;
  localparam int EX_MD_IS_MULT = 1;
  localparam int EX_MD_IS_UNSIGNED = 0;
  localparam int MEM_LHR_IS_MULT = 3;
  localparam int MEM_LHR_WEN = 2;
  localparam int MEM_LHR_REN = 1;
  localparam int MEM_LHR_IS_HI = 0;
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: 64-bit shift-add multiply / restoring divide datapath on magnitudes with 5-bit step counter
module md_iter_core
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_mult,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);
  logic [31:0] b_q;
  logic [4:0]  cnt;
  logic [32:0] sum;
  logic [33:0] diff;
  assign sum = {1'b0, hi} + {1'b0, lo[0] ? b_q : 32'd0};
  assign diff = {1'b0, hi, lo[31]} - {2'b0, b_q};
  assign done = &cnt;
  always_ff @(posedge clk)
    if (rst) begin
      hi <= '0;
      lo <= '0;
      b_q <= '0;
      cnt <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      b_q <= b;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 5'd1;
      {hi, lo} <= is_mult ? {sum, lo[31:1]} :
                  diff[33] ? {hi[30:0], lo[31], lo[30:0], 1'b0} : {diff[31:0], lo[30:0], 1'b1};
    end
endmodule

// File: rtl/md_hilo_unit.sv
// md_hilo_unit: MIPS mult/div and HI/LO register unit with pipeline stall; define MD_FAST_MULT_EN for a single-cycle multiplier
module md_hilo_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  id_ex_ex,
  input  logic [12:0] id_ex_mem,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] hilo_rdata,
  output logic        md_busy,
  output logic        md_stall
);
  state_t state;
  logic start, move, read, is_hi, ex_mult, sgn, fast, idle, done;
  logic mult_q, neg_q, neg_r, bzero;
  logic [31:0] hi, lo, mag_a, mag_b, core_hi, core_lo;
  logic [63:0] fast_prod, prod;
  logic unused_bits;
  assign unused_bits = ^{id_ex_ex[9:2], id_ex_mem[12:4]};
  assign start = id_ex_mem[MEM_LHR_WEN] & id_ex_mem[MEM_LHR_IS_MULT];
  assign move = id_ex_mem[MEM_LHR_WEN] & ~id_ex_mem[MEM_LHR_IS_MULT];
  assign read = id_ex_mem[MEM_LHR_REN];
  assign is_hi = id_ex_mem[MEM_LHR_IS_HI];
  assign ex_mult = id_ex_ex[EX_MD_IS_MULT];
  assign sgn = ~id_ex_ex[EX_MD_IS_UNSIGNED];
  assign idle = state == IDLE;
  assign md_busy = ~idle;
  assign md_stall = md_busy & (start | move | read);
  assign hilo_rdata = is_hi ? hi : lo;
  assign mag_a = (sgn & op_a[31]) ? -op_a : op_a;
  assign mag_b = (sgn & op_b[31]) ? -op_b : op_b;
  assign prod = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
`ifdef MD_FAST_MULT_EN
  assign fast = ex_mult;
  assign fast_prod = {{32{sgn & op_a[31]}}, op_a} * {{32{sgn & op_b[31]}}, op_b};
`else
  assign fast = 1'b0;
  assign fast_prod = '0;
`endif
  md_iter_core u_core (
    .clk(clk),
    .rst(rst),
    .load(idle & start & ~fast),
    .step(state == ITER),
    .is_mult(mult_q),
    .a(mag_a),
    .b(mag_b),
    .hi(core_hi),
    .lo(core_lo),
    .done(done)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      mult_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bzero <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start & fast) {hi, lo} <= fast_prod;
          else if (start) begin
            state <= ITER;
            mult_q <= ex_mult;
            neg_q <= sgn & (op_a[31] ^ op_b[31]);
            neg_r <= sgn & op_a[31];
            bzero <= ~|op_b;
          end else if (move & is_hi) hi <= op_a;
          else if (move) lo <= op_a;
        ITER: if (done) state <= FIX;
        FIX: begin
          state <= IDLE;
          hi <= mult_q ? prod[63:32] : (neg_r ? -core_hi : core_hi);
          lo <= mult_q ? prod[31:0] : bzero ? '1 : (neg_q ? -core_lo : core_lo);
        end
        default: state <= IDLE;
      endcase
endmodule
